id_ex_stage_reg: RTL and testbench

//   Parametrised ID/EX pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/id_ex_stage_reg.sv | 181 ++++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline stage register with a valid/ready handshake and a 2-entry
//   skid buffer. It carries the decoded operand bundle (pc4, rd1, rd2, imm,
//   jtgt, rt, rd) and the control bundle from decode to execute.
//
//   Storage is a main entry, which drives the outputs, plus a skid entry that
//   catches a bundle accepted while execute is stalled. in_ready only looks at
//   the skid entry, so it never depends on out_ready. This keeps the
//   back-pressure path registered and still allows one bundle per cycle.
//
// Configuration macro:
//   ID_EX_STALL_CNT_EN - adds the stall_cnt port. It counts the cycles with
//                        out_valid & ~out_ready, saturates, and is cleared
//                        only by rst.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (wins over flush and fires)
//   flush      drop all held and incoming bundles (branch/jump redirect)
//   in_valid   decode presents a bundle
//   in_ready   stage can accept a bundle (= skid entry empty)
//   in_*       incoming datapath words, register specifiers and control
//   out_valid  execute sees a valid bundle
//   out_ready  execute consumes the bundle this cycle
//   out_*      registered bundle from the main entry (ctrl is 0 when invalid)
//   stall_cnt  saturating stall-cycle counter (ID_EX_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_jtgt,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc4,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_jtgt,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // The data payload is packed as {pc4, rd1, rd2, imm, jtgt, rt, rd}.
    // Control is kept separate because it obeys the bubble rule, while data
    // is simply held when an entry goes invalid.
    localparam int PAY_W   = 5 * DATA_W + 2 * REG_W;
    localparam int RD_LSB  = 0;
    localparam int RT_LSB  = RD_LSB + REG_W;
    localparam int JT_LSB  = RT_LSB + REG_W;
    localparam int IMM_LSB = JT_LSB + DATA_W;
    localparam int RD2_LSB = IMM_LSB + DATA_W;
    localparam int RD1_LSB = RD2_LSB + DATA_W;
    localparam int PC4_LSB = RD1_LSB + DATA_W;

    // State encoding is {skidValid, mainValid}. The value 2'b10 is never
    // entered, and the default branch below recovers from it if it appears.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t             state;
    logic [PAY_W-1:0]   mainData;
    logic [PAY_W-1:0]   skidData;
    logic [CTRL_W-1:0]  mainCtrl;
    logic [CTRL_W-1:0]  skidCtrl;
    logic [PAY_W-1:0]   inData;
    logic               inFire;
    logic               outFire;

    assign inData = {in_pc4, in_rd1, in_rd2, in_imm, in_jtgt, in_rt, in_rd};

    // Handshake flags come straight from the state register.
    assign out_valid = (state == ONE) || (state == TWO);
    assign in_ready  = (state != TWO);
    assign inFire    = in_valid && in_ready;
    assign outFire   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            mainData <= '0;
            skidData <= '0;
            mainCtrl <= '0;
            skidCtrl <= '0;
        end else if (flush) begin
            // A bundle that fires together with flush is accepted and then
            // dropped. A bundle that leaves on out_fire has already been
            // consumed by execute this cycle.
            state    <= EMPTY;
            mainCtrl <= '0;
            skidCtrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (inFire) begin
                        mainData <= inData;
                        mainCtrl <= in_ctrl;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (inFire && outFire) begin
                        mainData <= inData;
                        mainCtrl <= in_ctrl;
                    end else if (outFire) begin
                        mainCtrl <= '0;
                        state    <= EMPTY;
                    end else if (inFire) begin
                        // Execute is stalled, so park the new bundle in the
                        // skid entry and drop in_ready next cycle.
                        skidData <= inData;
                        skidCtrl <= in_ctrl;
                        state    <= TWO;
                    end
                end
                TWO: begin
                    if (outFire) begin
                        mainData <= skidData;
                        mainCtrl <= skidCtrl;
                        skidCtrl <= '0;
                        state    <= ONE;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    mainCtrl <= '0;
                    skidCtrl <= '0;
                end
            endcase
        end
    end

    assign out_pc4  = mainData[PC4_LSB +: DATA_W];
    assign out_rd1  = mainData[RD1_LSB +: DATA_W];
    assign out_rd2  = mainData[RD2_LSB +: DATA_W];
    assign out_imm  = mainData[IMM_LSB +: DATA_W];
    assign out_jtgt = mainData[JT_LSB  +: DATA_W];
    assign out_rt   = mainData[RT_LSB  +: REG_W];
    assign out_rd   = mainData[RD_LSB  +: REG_W];
    assign out_ctrl = mainCtrl;

`ifdef ID_EX_STALL_CNT_EN
    // Flush does not clear the counter, so the count keeps the stall
    // history across redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    // Without the counter, CNT_W only sizes this tie-off.
    logic [CNT_W-1:0] unusedStallCnt;
    assign unusedStallCnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 11;
    localparam int CNT_W  = 4;
    localparam int BW     = 5 * DATA_W + 2 * REG_W + CTRL_W;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_pc4, in_rd1, in_rd2, in_imm, in_jtgt;
    logic [DATA_W-1:0] out_pc4, out_rd1, out_rd2, out_imm, out_jtgt;
    logic [REG_W-1:0]  in_rt, in_rd, out_rt, out_rd;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] sb[$];
    int nOut = 0;

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc4(in_pc4), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .in_jtgt(in_jtgt), .in_rt(in_rt), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc4(out_pc4), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
        .out_jtgt(out_jtgt), .out_rt(out_rt), .out_rd(out_rd), .out_ctrl(out_ctrl)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every field is derived from pc so that a swap or loss shows up in the whole bundle.
    task automatic drive(input logic v, input logic [DATA_W-1:0] pc, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_pc4   = pc;
        in_rd1   = pc * 3 + 1;
        in_rd2   = ~pc;
        in_imm   = {pc[15:0], ~pc[15:0]};
        in_jtgt  = pc << 2;
        in_rt    = pc[6:2];
        in_rd    = pc[6:2] ^ 5'h1f;
        in_ctrl  = c;
    endtask

    // One clock. Fires are judged from pre-edge values. Accepted bundles go
    // onto the scoreboard, and consumed bundles are popped and compared.
    // Flush or reset empties the scoreboard after that cycle's fires.
    task automatic cycle();
        logic inF, outF, clr;
        logic [BW-1:0] obs, exp;
        inF  = in_valid && in_ready;
        outF = out_valid && out_ready;
        clr  = rst || flush;
        if (outF) begin
            obs = {out_pc4, out_rd1, out_rd2, out_imm, out_jtgt, out_rt, out_rd, out_ctrl};
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                exp = sb.pop_front();
                chk("out_bundle", obs, exp);
                nOut++;
            end
        end
        if (inF) sb.push_back({in_pc4, in_rd1, in_rd2, in_imm, in_jtgt, in_rt, in_rd, in_ctrl});
        @(posedge clk);
        #1;
        if (clr) sb.delete();
        if (!rst) chk("bubble_ctrl", (out_valid === 1'b1 || out_ctrl === '0), 1);
    endtask

    initial begin
        rst = 1; flush = 0; out_ready = 0;
        drive(0, 0, 0);

        // 1) reset
        cycle(); cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_outs", {out_pc4, out_rd1, out_rd2, out_imm, out_jtgt, out_rt, out_rd}, 0);
`ifdef ID_EX_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        rst = 0;

        // 2) back-to-back streaming
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 32'(4 * i), 11'(i * 37));
            cycle();
            chk("stream_out_valid", out_valid, 1);
            chk("stream_in_ready", in_ready, 1);
            chk("stream_pc4", out_pc4, 32'(4 * i));
        end
        drive(0, 0, 0);
        cycle();
        chk("stream_drained", out_valid, 0);
        chk("stream_count", nOut, 4);
        chk("stream_sb_empty", sb.size(), 0);

        // 3) skid fill under stall, then drain
        out_ready = 0;
        drive(1, 32'h100, 11'h155); cycle();
        drive(1, 32'h200, 11'h2AA); cycle();
        chk("skid_in_ready", in_ready, 0);
        chk("skid_main_pc4", out_pc4, 32'h100);
        drive(1, 32'h300, 11'h0F3); cycle();
        chk("skid_hold_in_ready", in_ready, 0);
        chk("skid_hold_pc4", out_pc4, 32'h100);
        out_ready = 1;
        cycle();
        chk("drain_B_valid", out_valid, 1);
        chk("drain_B_pc4", out_pc4, 32'h200);
        cycle();
        drive(0, 0, 0);
        chk("drain_C_pc4", out_pc4, 32'h300);
        cycle();
        chk("drain_done", out_valid, 0);
        chk("drain_count", nOut, 7);
        chk("drain_sb_empty", sb.size(), 0);

        // 4) flush in TWO with in_valid high
        out_ready = 0;
        drive(1, 32'h400, 11'h7F0); cycle();
        drive(1, 32'h500, 11'h70F); cycle();
        chk("pre_flush_in_ready", in_ready, 0);
        drive(1, 32'h600, 11'h7FF); flush = 1; cycle();
        flush = 0; drive(0, 0, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_ctrl", out_ctrl, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1;
        cycle(); cycle();
        chk("flush_no_leak", out_valid, 0);
        chk("flush_count", nOut, 7);

        // flush in ONE with an accepted bundle and a completing out_fire
        drive(1, 32'h700, 11'h011); cycle();
        drive(1, 32'h800, 11'h022); flush = 1; cycle();
        flush = 0; drive(0, 0, 0);
        chk("flush1_count", nOut, 8);
        chk("flush1_out_valid", out_valid, 0);
        cycle();
        chk("flush1_no_leak", out_valid, 0);

        // 5) reset during a stall with all ctrl bits set
        out_ready = 0;
        drive(1, 32'h900, 11'h7FF); cycle();
        drive(0, 0, 0);
        chk("pre_rst_ctrl", out_ctrl, 11'h7FF);
        cycle();
        rst = 1; cycle(); rst = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_ctrl", out_ctrl, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_outs", {out_pc4, out_rd1, out_rd2, out_imm, out_jtgt, out_rt, out_rd}, 0);

`ifdef ID_EX_STALL_CNT_EN
        // 6) stall counter saturation; flush does not clear it, reset does
        chk("cnt_after_rst", stall_cnt, 0);
        drive(1, 32'hA00, 11'h001); cycle();
        drive(0, 0, 0);
        cycle();
        chk("cnt_first", stall_cnt, 1);
        for (int i = 0; i < 19; i++) cycle();
        chk("cnt_saturated", stall_cnt, 15);
        flush = 1; cycle(); flush = 0;
        chk("cnt_after_flush", stall_cnt, 15);
        rst = 1; cycle(); rst = 0;
        chk("cnt_after_rst2", stall_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
